// File: rtl/axis_dwc_pkg.sv
// ============================================================================
// Module  : axis_dwc_pkg
// Purpose : Shared helpers for the AXI-Stream width down-converter.
//           ceil_div   - integer ceiling division
//           keep_count - number of set bits in an LSB-contiguous keep mask
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_dwc_pkg;

  // Widest keep mask keep_count can inspect; callers zero-extend into it.
  localparam int MAX_KEEP_W = 256;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Upstream guarantees keep is LSB-contiguous, so the popcount equals the
  // number of leading valid words.
  function automatic int keep_count(input logic [MAX_KEEP_W-1:0] keep,
                                    input int                    width);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      if (i < width && keep[i]) begin
        cnt = cnt + 1;
      end
    end
    return cnt;
  endfunction

endpackage : axis_dwc_pkg

`default_nettype wire

// File: rtl/axis_downsizer_if.sv
// ============================================================================
// Module  : axis_downsizer_if
// Purpose : AXI-Stream bundle (valid/ready/data/keep/last) of WORDS words.
// Ports   : none; modports
//           master - drives valid/data/keep/last, receives ready
//           slave  - receives valid/data/keep/last, drives ready
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axis_downsizer_if #(
  parameter int WORD_W = 8,
  parameter int WORDS  = 4
);

  logic                          valid;
  logic                          ready;
  logic [WORDS-1:0][WORD_W-1:0]  data;   // word 0 first on the wire
  logic [WORDS-1:0]              keep;
  logic                          last;

  modport master (output valid, output data, output keep, output last,
                  input  ready);

  modport slave  (input  valid, input  data, input  keep, input  last,
                  output ready);

endinterface : axis_downsizer_if

`default_nettype wire

// File: rtl/axis_downsizer.sv
// ============================================================================
// Module  : axis_downsizer
// Purpose : AXI-Stream data-width down-converter. Each accepted wide beat of
//           S_WORDS words is held in a one-beat register and re-emitted as
//           N narrow slices of M_WORDS words, preserving keep and last.
//           The next wide beat is accepted in the same cycle the final slice
//           leaves, so the output side runs at full throughput.
// Ports   : clk    - clock
//           rst    - synchronous active-high reset
//           s_axis - wide input stream  (slave modport,  S_WORDS words)
//           m_axis - narrow output stream (master modport, M_WORDS words)
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_downsizer
  import axis_dwc_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int S_BUS_W = 32,
  parameter int M_BUS_W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  axis_downsizer_if.slave   s_axis,
  axis_downsizer_if.master  m_axis
);

  localparam int S_WORDS = S_BUS_W / WORD_W;
  localparam int M_WORDS = M_BUS_W / WORD_W;
  localparam int R       = S_WORDS / M_WORDS;
  localparam int IDX_W   = $clog2(R + 1);
  localparam int K_W     = $clog2(S_WORDS + 1);
  localparam int SLICE_W = M_WORDS * WORD_W;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_BUSY  = 1'b1;

  // --------------------------------------------------------------------------
  // Elaboration-time geometry check
  // --------------------------------------------------------------------------
  if ((S_WORDS % M_WORDS) != 0) begin : g_bad_ratio
    $fatal(1, "axis_downsizer: S_WORDS (%0d) must be a multiple of M_WORDS (%0d)",
           S_WORDS, M_WORDS);
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]                r_state;
  logic [R-1:0][SLICE_W-1:0] r_data;   // held wide beat, viewed as R slices
  logic                      r_last;
  logic [K_W-1:0]            r_k;      // valid words in held beat
  logic [IDX_W-1:0]          r_n;      // slices to emit for held beat
  logic [IDX_W-1:0]          r_idx;    // slice currently presented

  logic [K_W-1:0]            w_k;
  logic [IDX_W-1:0]          w_n;
  logic                      w_busy;
  logic                      w_final;
  logic                      w_s_ready;
  logic                      w_s_hs;
  logic                      w_m_hs;
  logic [SLICE_W-1:0]        w_slice;
  logic [M_WORDS-1:0]        w_keep;

  // --------------------------------------------------------------------------
  // Capture-side decode: word count and slice count of the incoming beat
  // --------------------------------------------------------------------------
  always_comb begin
    w_k = K_W'(keep_count(MAX_KEEP_W'(s_axis.keep), S_WORDS));
    w_n = '0;
    if (w_k == '0) begin
      // An empty last beat still needs one slice to carry m_last.
      w_n = s_axis.last ? IDX_W'(1) : '0;
    end else begin
      w_n = IDX_W'(ceil_div(int'(w_k), M_WORDS));
    end
  end

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  assign w_busy  = (r_state == ST_BUSY);
  assign w_final = w_busy && (r_idx == (r_n - IDX_W'(1)));

  // Ready to take a new beat when nothing is held, or when the final slice
  // is leaving this cycle (combinational path from m_axis.ready).
  assign w_s_ready = !rst && (!w_busy || (w_final && m_axis.ready));
  assign w_s_hs    = s_axis.valid && w_s_ready;
  assign w_m_hs    = w_busy && m_axis.ready;

  assign s_axis.ready = w_s_ready;

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_idx   <= '0;
      r_n     <= '0;
      r_k     <= '0;
      r_last  <= 1'b0;
    end else if (w_s_hs) begin
      // Covers both the EMPTY capture and the final-slice + new-beat overlap.
      r_last  <= s_axis.last;
      r_k     <= w_k;
      r_n     <= w_n;
      r_idx   <= '0;
      // A zero-keep non-last beat yields N==0 and is silently dropped.
      r_state <= (w_n != '0) ? ST_BUSY : ST_EMPTY;
    end else if (w_m_hs) begin
      if (w_final) begin
        r_state <= ST_EMPTY;
        r_idx   <= '0;
      end else begin
        r_idx   <= r_idx + IDX_W'(1);
      end
    end
  end

  // Datapath holding register; contents are don't-care while EMPTY.
  always_ff @(posedge clk) begin
    if (w_s_hs) begin
      r_data <= s_axis.data;
    end
  end

  // --------------------------------------------------------------------------
  // Output slice mux (registered sources only: no s_* to m_* path)
  // --------------------------------------------------------------------------
  always_comb begin
    w_slice = '0;
    for (int i = 0; i < R; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_slice = r_data[i];
      end
    end
  end

  always_comb begin
    w_keep = '0;
    for (int j = 0; j < M_WORDS; j++) begin
      w_keep[j] = w_busy && ((int'(r_idx) * M_WORDS + j) < int'(r_k));
    end
  end

  assign m_axis.valid = w_busy;
  assign m_axis.data  = w_slice;
  assign m_axis.keep  = w_keep;
  assign m_axis.last  = w_final && r_last;

endmodule : axis_downsizer

`default_nettype wire

// File: doc/axis_downsizer.md
# axis_downsizer

AXI-Stream data-width down-converter that accepts wide beats of `S_WORDS` words and re-emits them as narrower beats of `M_WORDS` words. Packet boundaries and per-word keep are preserved. It sits directly downstream of a wide stream source and feeds narrow consumers. Output is driven from a one-beat holding register, so a new input beat is accepted in the same cycle the last slice of the previous beat leaves. The result is full output throughput.

## Interface
- `WORD_W`, default 8: bits per word.
- `S_BUS_W`, default 32: input bus width; `S_WORDS = S_BUS_W/WORD_W`.
- `M_BUS_W`, default 8: output bus width; `M_WORDS = M_BUS_W/WORD_W`. `S_WORDS % M_WORDS == 0` is required; otherwise the design raises an elaboration `$fatal`.
- `R` (localparam): `S_WORDS/M_WORDS`, the number of output slices per input beat.
- `clk` input 1: clock. Single clock domain.
- `rst` input 1: reset, synchronous, active-high.
- `s_valid` input 1: input beat valid.
- `s_ready` output 1: input beat accepted when `s_valid && s_ready` at the rising edge of `clk`.
- `s_data` input `[S_WORDS-1:0][WORD_W-1:0]`: input words; word 0 comes first.
- `s_keep` input `S_WORDS`: per-word valid. The upstream guarantees keep is LSB-contiguous.
- `s_last` input 1: final beat of a packet.
- `m_valid` output 1: output beat valid.
- `m_ready` input 1: downstream ready.
- `m_data` output `[M_WORDS-1:0][WORD_W-1:0]`: output words.
- `m_keep` output `M_WORDS`: per-word valid on the output.
- `m_last` output 1: final output beat of a packet.

## Operation
- **Capture.** On an input handshake, register the following:
  - `s_data`;
  - `s_last`;
  - `K`, the count of set `s_keep` bits (0..`S_WORDS`);
  - `N`, the number of output slices: `N = ceil(K/M_WORDS)`, except `N=1` when `K==0` and `s_last==1`.
- **States.**
  - EMPTY: `m_valid=0`.
  - BUSY: `m_valid=1`, with slice index `idx` in 0..`N-1`.
- **Transitions.**
  - EMPTY to BUSY on capture with `N>0`.
  - A captured beat with `K==0 && !s_last` is accepted and discarded; the block stays EMPTY.
  - In BUSY, each output handshake increments `idx`.
  - On the handshake at `idx==N-1`, the block either captures the next beat (if `s_valid`) or returns to EMPTY.
- **Output slice for index `idx`:**
  - `m_data[j] = held[idx*M_WORDS+j]`;
  - `m_keep[j] = (idx*M_WORDS+j < K)`;
  - `m_last = held_last && idx==N-1`.
- **Handshake.**
  - `s_ready = !rst && (EMPTY || (idx==N-1 && m_ready))`.
  - `s_ready` has a combinational path from `m_ready`.
  - There is no combinational path from `s_*` to `m_*`.
- **Words with keep=0.** `m_data` words whose keep bit is 0 are don't-care.
- **Width rules.**
  - `idx` and `N` are `$clog2(R+1)` bits wide.
  - `K` is `$clog2(S_WORDS+1)` bits wide.
  - When `R==1`, the block degenerates to a one-deep register stage with keep and last passed through.

## Timing
- **Reset.**
  - In the cycle after `rst` is sampled high: `m_valid=0`, `m_keep=0`, `m_last=0`, `idx=0`, state EMPTY.
  - `s_ready=0` while `rst` is high.
- **Latency.** A beat accepted at edge *k* presents slice 0 on `m_*` from edge *k* onward, i.e. valid during cycle *k+1*.
- **Throughput.**
  - One output beat per cycle while `m_ready=1` and input is available.
  - `s_ready` is high once per `N` output cycles, with no bubble between input beats or between packets.
- **Backpressure.** While `m_valid && !m_ready`, `m_data`, `m_keep` and `m_last` are held stable and `s_ready=0` (if BUSY).
- **Simultaneous events.** On the final-slice handshake plus an input handshake in the same cycle, the new beat's slice 0 appears the next cycle.
- **Reset mid-packet.** The held beat is dropped. No partial `m_last` is generated. The next accepted beat starts at `idx=0`.
- **Input protocol.** `s_valid` may toggle arbitrarily. The block never requires `s_valid` to be held.

## Structure
- **Package `axis_dwc_pkg`** contains:
  - the `ceil_div(a,b)` function;
  - the `keep_count` function (popcount of LSB-contiguous keep).
- **Modules.** Single module, no sub-module. The holding register, slice counter and slice mux are all in `axis_downsizer`.

## Test plan
All scenarios use `WORD_W=8`. Scenarios 1–3 and 5–6 use `S_BUS_W=32`, `M_BUS_W=8`. Scenario 4 uses `M_BUS_W=16`.

1. **Basic packet.**
   - Stimulus: 10-word packet 1..10 sent as 3 beats (last keep `0011`), with `m_ready=1`.
   - Required: 10 output beats with data 1..10, keep=1 on each, `m_last` only on data 10.
2. **Backpressure.**
   - Stimulus: `m_ready` low for 5 cycles while the slice with data 3 is presented.
   - Required: `m_data=3` stable, `s_ready=0` throughout, and no word lost or duplicated afterwards.
3. **Streaming.**
   - Stimulus: `s_valid` and `m_ready` held at 1 across two back-to-back 8-word packets.
   - Required: 16 consecutive output cycles with `m_valid=1`, `s_ready` high every 4th cycle, `m_last` on outputs 8 and 16.
4. **Partial final slice (`M_BUS_W=16`).**
   - Stimulus: 5-word packet 1..5.
   - Required output beats:
     - {1,2} with keep `11`;
     - {3,4} with keep `11`;
     - {5,–} with keep `01` and `m_last=1`.
5. **Zero-keep beats.**
   - Stimulus: a non-last beat with keep `0000`, then a last beat with keep `0000`.
   - Required: the first beat is discarded with no output; the second produces exactly one output beat with keep=0 and `m_last=1`.
6. **Reset mid-packet.**
   - Stimulus: `rst` asserted for 1 cycle during slice 2 of an 8-word packet, then a fresh 7-word packet 20..26.
   - Required: `m_valid=0` the cycle after reset, then output 20..26 with `m_last` only on 26.
